// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register ids, status codes.
// Used by both decode and writeback.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int         NREG  = 15;
  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  function automatic logic icode_valid(input logic [3:0] ic);
    return ic <= I_POPQ;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: two async read ports (RNONE reads 0), two sync write ports.
// Write latency 1 cycle, no read bypass; port M wins a same-address write; no backpressure.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a_i,
  input  logic [3:0]  src_b_i,
  output logic [63:0] rd_a_o,
  output logic [63:0] rd_b_o,
  input  logic        we_e_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i,
  output logic [63:0] regs_o [NREG]
);

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];

  // M is applied last so popq %rsp keeps the loaded value rather than the stack pointer.
  always_comb begin
    regs_d = regs_q;
    if (we_e_i) regs_d[dst_e_i] = val_e_i;
    if (we_m_i) regs_d[dst_m_i] = val_m_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_a_o = (src_a_i == RNONE) ? 64'd0 : regs_q[src_a_i];
    rd_b_o = (src_b_i == RNONE) ? 64'd0 : regs_q[src_b_i];
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/writeback.sv
// Y86-64 write-back: register selection, commit, status FSM and retired-instruction count.
// Commit lands 1 cycle after the wb_valid edge; no backpressure, retirement stops once stat leaves AOK.
module writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] reg_arr0,
  output logic [63:0] reg_arr1,
  output logic [63:0] reg_arr2,
  output logic [63:0] reg_arr3,
  output logic [63:0] reg_arr4,
  output logic [63:0] reg_arr5,
  output logic [63:0] reg_arr6,
  output logic [63:0] reg_arr7,
  output logic [63:0] reg_arr8,
  output logic [63:0] reg_arr9,
  output logic [63:0] reg_arr10,
  output logic [63:0] reg_arr11,
  output logic [63:0] reg_arr12,
  output logic [63:0] reg_arr13,
  output logic [63:0] reg_arr14,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] instret
);

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic        fault, retire_ok;
  logic [63:0] regs [NREG];
  stat_t       stat_q, stat_d;
  logic [63:0] instret_q, instret_d;

  // ifun only matters to execute; cmov qualification arrives already folded into cnd.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
      I_RET, I_POPQ:                      src_a = RRSP;
      default: ;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RRSP;
      default: ;
    endcase
    case (icode)
      I_RRMOVQ:                           dst_e = cnd ? rB : RNONE;
      I_IRMOVQ, I_OPQ:                    dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RRSP;
      default: ;
    endcase
    case (icode)
      I_MRMOVQ, I_POPQ:                   dst_m = rA;
      default: ;
    endcase
  end

  assign fault     = imem_error || dmem_error || !icode_valid(icode);
  assign retire_ok = wb_valid && (stat_q == STAT_AOK) && !fault;

  y86_regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .rd_a_o  (valA),
    .rd_b_o  (valB),
    .we_e_i  (retire_ok && (dst_e != RNONE)),
    .dst_e_i (dst_e),
    .val_e_i (valE),
    .we_m_i  (retire_ok && (dst_m != RNONE)),
    .dst_m_i (dst_m),
    .val_m_i (valM),
    .regs_o  (regs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q    <= STAT_AOK;
      instret_q <= 64'd0;
    end else begin
      stat_q    <= stat_d;
      instret_q <= instret_d;
    end
  end

  // Address faults outrank an invalid icode, which outranks halt.
  always_comb begin
    stat_d = stat_q;
    if (wb_valid && stat_q == STAT_AOK) begin
      if (imem_error || dmem_error) stat_d = STAT_ADR;
      else if (!icode_valid(icode)) stat_d = STAT_INS;
      else if (icode == I_HALT)     stat_d = STAT_HLT;
    end
  end

  always_comb begin
    instret_d = retire_ok ? instret_q + 64'd1 : instret_q;
  end

  always_comb begin
    stat    = stat_q;
    halted  = (stat_q != STAT_AOK);
    instret = instret_q;
  end

  assign reg_arr0  = regs[0];
  assign reg_arr1  = regs[1];
  assign reg_arr2  = regs[2];
  assign reg_arr3  = regs[3];
  assign reg_arr4  = regs[4];
  assign reg_arr5  = regs[5];
  assign reg_arr6  = regs[6];
  assign reg_arr7  = regs[7];
  assign reg_arr8  = regs[8];
  assign reg_arr9  = regs[9];
  assign reg_arr10 = regs[10];
  assign reg_arr11 = regs[11];
  assign reg_arr12 = regs[12];
  assign reg_arr13 = regs[13];
  assign reg_arr14 = regs[14];

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: commit, cmov, popq priority, halt/fault/invalid status and reset.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst, wb_valid, cnd, imem_error, dmem_error;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valE, valM, valA, valB, instret;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] ra [15];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  writeback #(.RSP_INIT(64'h100)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .imem_error(imem_error), .dmem_error(dmem_error),
    .valA(valA), .valB(valB),
    .reg_arr0(ra[0]), .reg_arr1(ra[1]), .reg_arr2(ra[2]), .reg_arr3(ra[3]),
    .reg_arr4(ra[4]), .reg_arr5(ra[5]), .reg_arr6(ra[6]), .reg_arr7(ra[7]),
    .reg_arr8(ra[8]), .reg_arr9(ra[9]), .reg_arr10(ra[10]), .reg_arr11(ra[11]),
    .reg_arr12(ra[12]), .reg_arr13(ra[13]), .reg_arr14(ra[14]),
    .stat(stat), .halted(halted), .instret(instret)
  );

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic retire(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [63:0] e, input logic [63:0] m,
                        input logic ie, input logic de);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    imem_error = ie; dmem_error = de; wb_valid = 1'b1;
    @(posedge clk); #1;
    wb_valid = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tests++;
      if (ra[i] !== ((i == 4) ? 64'h100 : 64'd0)) begin
        fails++; $display("FAIL reset_reg%0d: got %h expected %h", i, ra[i], (i == 4) ? 64'h100 : 64'd0);
      end
    end
    tests++;
    if (stat !== 3'd1 || halted !== 1'b0) begin
      fails++; $display("FAIL reset_stat: got stat=%0d halted=%b expected 1/0", stat, halted);
    end
    tests++;
    if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    icode = 4'h2; rA = 4'd4; rB = 4'hF; #1;
    tests++;
    if (valA !== 64'h100) begin fails++; $display("FAIL reset_valA: got %h expected 100", valA); end
  endtask

  task automatic test_irmovq();
    retire(4'h3, 4'hF, 4'd2, 1'b0, 64'd7, 64'd0, 1'b0, 1'b0);
    tests++;
    if (ra[2] !== 64'd7) begin fails++; $display("FAIL irmovq_reg2: got %h expected 7", ra[2]); end
    tests++;
    if (instret !== 64'd1) begin fails++; $display("FAIL irmovq_instret: got %0d expected 1", instret); end
    // Idle cycle: wb_valid low must neither write nor count.
    icode = 4'h3; rB = 4'd2; valE = 64'd99; wb_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ra[2] !== 64'd7 || instret !== 64'd1) begin
      fails++; $display("FAIL idle_hold: got reg2=%h instret=%0d expected 7/1", ra[2], instret);
    end
  endtask

  task automatic test_cmov();
    retire(4'h2, 4'd2, 4'd3, 1'b0, 64'd9, 64'd0, 1'b0, 1'b0);
    tests++;
    if (ra[3] !== 64'd0 || instret !== 64'd2) begin
      fails++; $display("FAIL cmov_nc: got reg3=%h instret=%0d expected 0/2", ra[3], instret);
    end
    // Same-cycle read returns pre-write contents.
    icode = 4'h2; rA = 4'd3; rB = 4'd3; cnd = 1'b1; valE = 64'd9; wb_valid = 1'b1; #1;
    tests++;
    if (valA !== 64'd0) begin fails++; $display("FAIL no_bypass: got %h expected 0", valA); end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    tests++;
    if (ra[3] !== 64'd9 || instret !== 64'd3) begin
      fails++; $display("FAIL cmov_c: got reg3=%h instret=%0d expected 9/3", ra[3], instret);
    end
    tests++;
    if (valA !== 64'd9) begin fails++; $display("FAIL read_after_write: got %h expected 9", valA); end
  endtask

  task automatic test_popq();
    retire(4'hB, 4'd4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b0, 1'b0);
    tests++;
    if (ra[4] !== 64'h55) begin fails++; $display("FAIL popq_rsp: got %h expected 55", ra[4]); end
    retire(4'hB, 4'd1, 4'hF, 1'b0, 64'h110, 64'hAB, 1'b0, 1'b0);
    tests++;
    if (ra[1] !== 64'hAB || ra[4] !== 64'h110) begin
      fails++; $display("FAIL popq_r1: got reg1=%h reg4=%h expected ab/110", ra[1], ra[4]);
    end
    tests++;
    if (instret !== 64'd5) begin fails++; $display("FAIL popq_instret: got %0d expected 5", instret); end
    icode = 4'hA; rA = 4'd1; rB = 4'hF; #1;
    tests++;
    if (valA !== 64'hAB || valB !== 64'h110) begin
      fails++; $display("FAIL pushq_reads: got valA=%h valB=%h expected ab/110", valA, valB);
    end
  endtask

  task automatic test_halt();
    retire(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    tests++;
    if (stat !== 3'd2 || halted !== 1'b1 || instret !== 64'd6) begin
      fails++; $display("FAIL halt: got stat=%0d halted=%b instret=%0d expected 2/1/6", stat, halted, instret);
    end
    retire(4'h3, 4'hF, 4'd5, 1'b0, 64'h77, 64'd0, 1'b0, 1'b0);
    tests++;
    if (ra[5] !== 64'd0 || instret !== 64'd6 || stat !== 3'd2) begin
      fails++; $display("FAIL after_halt: got reg5=%h instret=%0d stat=%0d expected 0/6/2", ra[5], instret, stat);
    end
  endtask

  task automatic test_faults();
    do_reset();
    retire(4'h5, 4'd6, 4'd3, 1'b0, 64'd0, 64'h33, 1'b0, 1'b1);
    tests++;
    if (stat !== 3'd3 || ra[6] !== 64'd0 || instret !== 64'd0) begin
      fails++; $display("FAIL dmem_fault: got stat=%0d reg6=%h instret=%0d expected 3/0/0", stat, ra[6], instret);
    end
    do_reset();
    retire(4'h3, 4'hF, 4'd7, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0);
    retire(4'hC, 4'd7, 4'd7, 1'b0, 64'd1, 64'd2, 1'b0, 1'b0);
    tests++;
    if (stat !== 3'd4 || ra[7] !== 64'd5 || instret !== 64'd1) begin
      fails++; $display("FAIL invalid_icode: got stat=%0d reg7=%h instret=%0d expected 4/5/1", stat, ra[7], instret);
    end
    // Reset wins over a concurrent retire.
    icode = 4'h3; rB = 4'd8; valE = 64'h99; wb_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_valid = 1'b0;
    tests++;
    if (stat !== 3'd1 || halted !== 1'b0 || instret !== 64'd0) begin
      fails++; $display("FAIL rst_stat: got stat=%0d halted=%b instret=%0d expected 1/0/0", stat, halted, instret);
    end
    tests++;
    if (ra[7] !== 64'd0 || ra[8] !== 64'd0 || ra[4] !== 64'h100) begin
      fails++; $display("FAIL rst_regs: got r7=%h r8=%h r4=%h expected 0/0/100", ra[7], ra[8], ra[4]);
    end
    retire(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    tests++;
    if (stat !== 3'd3 || instret !== 64'd0) begin
      fails++; $display("FAIL adr_priority: got stat=%0d instret=%0d expected 3/0", stat, instret);
    end
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; cnd = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valE = 64'd0; valM = 64'd0;
    @(negedge clk);
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq();
    test_halt();
    test_faults();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
